expr_string_tx: RTL

// Transmit side of the expression character stream: collects a tokenised

---
 rtl/expr_string_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/expr_string_tx.sv
// Expression character transmitter: validates and buffers a tokenised expression
// (digit / op alternation), then streams it as gap-free ASCII after a chk_clr pulse.
module expr_string_tx #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tok_valid,
    output logic       tok_ready,
    input  logic       tok_op,
    input  logic [3:0] tok_val,
    input  logic       tok_last,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       chk_clr,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {S_LOAD, S_SYNC, S_SEND, S_ERR} state_t;

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_LIM  = (AW+1)'(DEPTH - 2);

    state_t          r_state, w_state_n;
    logic [AW-1:0]   r_wptr, w_wptr_n, r_rptr, w_rptr_n;
    logic [AW:0]     r_cnt, w_cnt_n;
    logic            r_exp_op, w_exp_op_n;
    logic            r_err_last, w_err_last_n;
    logic [7:0]      r_out, w_out_n;
    logic            r_out_valid, w_out_valid_n;
    logic            r_chk_clr, w_chk_clr_n;
    logic            w_full, w_accept, w_bad, w_wr_en;
    logic [4:0]      w_head;
    logic [4:0]      r_buf [DEPTH];

    // Buffer entry is {op, val}; op code 1 is '*', 0 is '+'.
    function automatic logic [7:0] ascii_of(input logic [4:0] ent);
        if (ent[4])
            return ent[0] ? 8'h2A : 8'h2B;
        return 8'h30 + {4'h0, ent[3:0]};
    endfunction

    assign w_full    = (r_cnt == C_FULL);
    assign tok_ready = !clr && (((r_state == S_LOAD) && !w_full) || (r_state == S_ERR));
    assign w_accept  = tok_valid && tok_ready;
    assign w_head    = r_buf[r_rptr];

    // The (DEPTH-1)-th token must close the expression, so length errors surface here.
    assign w_bad = (tok_op != r_exp_op)
                || (!tok_op && (tok_val > 4'd9))
                || (tok_op && (tok_val > 4'd1))
                || (tok_op && tok_last)
                || ((r_cnt == C_LIM) && !tok_last);

    always_comb begin
        w_state_n     = r_state;
        w_wptr_n      = r_wptr;
        w_rptr_n      = r_rptr;
        w_cnt_n       = r_cnt;
        w_exp_op_n    = r_exp_op;
        w_err_last_n  = r_err_last;
        w_out_n       = 8'h00;
        w_out_valid_n = 1'b0;
        w_chk_clr_n   = 1'b0;
        w_wr_en       = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_state_n    = S_ERR;
                        w_err_last_n = tok_last;
                    end else begin
                        w_wr_en  = 1'b1;
                        w_wptr_n = r_wptr + AW'(1);
                        w_cnt_n  = r_cnt + (AW+1)'(1);
                        if (tok_last) begin
                            w_state_n   = S_SYNC;
                            w_chk_clr_n = 1'b1;
                        end else begin
                            w_exp_op_n = !r_exp_op;
                        end
                    end
                end
            end
            S_SYNC: begin
                w_state_n     = S_SEND;
                w_out_n       = ascii_of(w_head);
                w_out_valid_n = 1'b1;
                w_rptr_n      = r_rptr + AW'(1);
                w_cnt_n       = r_cnt - (AW+1)'(1);
            end
            S_SEND: begin
                if (r_cnt == '0) begin
                    w_state_n  = S_LOAD;
                    w_wptr_n   = '0;
                    w_rptr_n   = '0;
                    w_exp_op_n = 1'b0;
                end else begin
                    w_out_n       = ascii_of(w_head);
                    w_out_valid_n = 1'b1;
                    w_rptr_n      = r_rptr + AW'(1);
                    w_cnt_n       = r_cnt - (AW+1)'(1);
                end
            end
            S_ERR: begin
                // Offending token already carried last: leave after a single cycle.
                if (r_err_last || (w_accept && tok_last)) begin
                    w_state_n    = S_LOAD;
                    w_wptr_n     = '0;
                    w_rptr_n     = '0;
                    w_cnt_n      = '0;
                    w_exp_op_n   = 1'b0;
                    w_err_last_n = 1'b0;
                end
            end
            default: w_state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_LOAD;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_exp_op    <= 1'b0;
            r_err_last  <= 1'b0;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_chk_clr   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_wptr      <= w_wptr_n;
            r_rptr      <= w_rptr_n;
            r_cnt       <= w_cnt_n;
            r_exp_op    <= w_exp_op_n;
            r_err_last  <= w_err_last_n;
            r_out       <= w_out_n;
            r_out_valid <= w_out_valid_n;
            r_chk_clr   <= w_chk_clr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_buf[r_wptr] <= {tok_op, tok_val};
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign chk_clr   = r_chk_clr;
    assign busy      = (r_state == S_SYNC) || (r_state == S_SEND);
    assign err       = (r_state == S_ERR);

endmodule
